// File: rtl/lr3_disp_scan_if.sv
// Bus bundle for the 7-segment scan controller: scan tick, digit data/masks in, pin drivers out.
interface lr3_disp_scan_if #(
  parameter int DIGITS = 4
);
  logic                  ce;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     en_mask;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  seg_dp;
  logic                  frame;

  modport master (output ce, data, dp, en_mask, input an, seg, seg_dp, frame);
  modport slave  (input ce, data, dp, en_mask, output an, seg, seg_dp, frame);
endinterface

// File: rtl/lr3_disp_scan.sv
// Round-robin 7-segment scan controller with frame-latched data and registered active-low outputs.
// Define LR3_DISP_BLANK_EN to insert DEAD_TICKS of all-anodes-off between digits.
module lr3_disp_scan #(
  parameter int DIGITS     = 4,
  parameter int HOLD_TICKS = 4,
  parameter int DEAD_TICKS = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  lr3_disp_scan_if.slave bus
);
  localparam int IW   = $clog2(DIGITS);
  localparam int MAXT = (HOLD_TICKS > DEAD_TICKS) ? HOLD_TICKS : DEAD_TICKS;
  localparam int TW   = $clog2(MAXT) + 1;
  localparam logic [IW-1:0] LAST    = IW'(DIGITS - 1);
  localparam logic [TW-1:0] HOLD_M1 = TW'(HOLD_TICKS - 1);
`ifdef LR3_DISP_BLANK_EN
  localparam logic [TW-1:0] DEAD_M1 = TW'(DEAD_TICKS - 1);
`endif

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} phase_e;

  phase_e              ph_q, ph_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   dpsh_q, dpsh_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                sdp_q, sdp_d;
  logic                frame_q, frame_d;
  logic                adv, wrap;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ph_q     <= BLANK;
      idx_q    <= LAST;
      tcnt_q   <= '0;
      shadow_q <= '0;
      dpsh_q   <= '0;
      an_q     <= '1;
      seg_q    <= '1;
      sdp_q    <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      idx_q    <= idx_d;
      tcnt_q   <= tcnt_d;
      shadow_q <= shadow_d;
      dpsh_q   <= dpsh_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      sdp_q    <= sdp_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    ph_d     = ph_q;
    tcnt_d   = tcnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    dpsh_d   = dpsh_q;
    adv      = 1'b0;
    wrap     = 1'b0;
    if (bus.ce) begin
      case (ph_q)
        SHOW: begin
          if (tcnt_q == HOLD_M1) begin
            tcnt_d = '0;
`ifdef LR3_DISP_BLANK_EN
            ph_d   = BLANK;
`else
            adv    = 1'b1;
`endif
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: begin
`ifdef LR3_DISP_BLANK_EN
          if (tcnt_q == DEAD_M1) begin
            tcnt_d = '0;
            adv    = 1'b1;
            ph_d   = SHOW;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`else
          // Without blanking, BLANK only exists out of reset and leaves on the first tick.
          tcnt_d = '0;
          adv    = 1'b1;
          ph_d   = SHOW;
`endif
        end
      endcase
    end
    if (adv) begin
      wrap  = (idx_q == LAST);
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    // Latch the whole frame at once so mid-frame DATA changes cannot tear the display.
    if (wrap) begin
      shadow_d = bus.data;
      dpsh_d   = bus.dp;
    end
  end

  always_comb begin
    an_d    = '1;
    seg_d   = '1;
    sdp_d   = 1'b1;
    frame_d = wrap;
    if (ph_d == SHOW) begin
      an_d[idx_d] = ~bus.en_mask[idx_d];
      seg_d       = hex7(shadow_d[{idx_d, 2'b00} +: 4]);
      sdp_d       = ~(dpsh_d[idx_d] & bus.en_mask[idx_d]);
    end
  end

  assign bus.an     = an_q;
  assign bus.seg    = seg_q;
  assign bus.seg_dp = sdp_q;
  assign bus.frame  = frame_q;
endmodule

// File: tb/tb_lr3_disp_scan.sv
// Directed scoreboard bench for lr3_disp_scan: a reference model queues expected outputs per CE tick.
module tb_lr3_disp_scan;
  localparam int ND = 4, HT = 2, DT = 1;
`ifdef LR3_DISP_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       sdp;
    logic       frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lr3_disp_scan_if #(.DIGITS(ND)) bus();

  lr3_disp_scan #(.DIGITS(ND), .HOLD_TICKS(HT), .DEAD_TICKS(DT)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  exp_t q[$];
  exp_t last, tick_obs;
  int checks = 0, passes = 0;
  bit m_show;
  int m_idx, m_t;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;

  function automatic exp_t outs();
    return {bus.an, bus.seg, bus.seg_dp, bus.frame};
  endfunction

  task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_show = 1'b0; m_idx = ND - 1; m_t = 0; m_sh = '0; m_dp = '0;
    last = {4'hF, 7'h7F, 1'b1, 1'b0};
  endtask

  task automatic model_step();
    bit adv = 1'b0;
    if (!m_show) begin
      if (!BLK || m_t == DT - 1) begin m_t = 0; adv = 1'b1; m_show = 1'b1; end
      else m_t++;
    end else if (m_t == HT - 1) begin
      m_t = 0;
      if (BLK) m_show = 1'b0; else adv = 1'b1;
    end else m_t++;
    last.frame = 1'b0;
    if (adv) begin
      if (m_idx == ND - 1) begin
        m_idx = 0; m_sh = bus.data; m_dp = bus.dp; last.frame = 1'b1;
      end else m_idx++;
    end
    last.an = '1; last.seg = '1; last.sdp = 1'b1;
    if (m_show) begin
      last.an[m_idx] = ~bus.en_mask[m_idx];
      last.seg       = segtab[m_sh[m_idx*4 +: 4]];
      last.sdp       = ~(m_dp[m_idx] & bus.en_mask[m_idx]);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    cmp({tag, "_sb_depth"}, 16'(q.size()), 16'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      tick_obs = outs();
      cmp(tag, 16'(tick_obs), 16'(e));
    end
  endtask

  // One CE tick, then `idle` CE-low cycles during which the outputs must hold.
  task automatic tick(input int idle);
    exp_t h;
    @(negedge clk); bus.ce = 1'b1;
    model_step();
    q.push_back(last);
    @(posedge clk); #1;
    check_out("tick");
    if (idle > 0) begin
      @(negedge clk); bus.ce = 1'b0;
      h = last; h.frame = 1'b0;
      repeat (idle) begin
        @(posedge clk); #1;
        cmp("hold", 16'(outs()), 16'(h));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    cmp("reset_state", 16'(outs()), 16'({4'hF, 7'h7F, 1'b1, 1'b0}));
    model_reset();
    @(negedge clk); rst_n = 1'b1; bus.ce = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int f1, f2, n;
    bus.ce = 1'b0; bus.data = '0; bus.dp = '0; bus.en_mask = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // First frame of 1A3F: digit 0 shows F with FRAME.
    bus.data = 16'h1A3F;
    tick(4);
    cmp("first_slot", 16'(tick_obs), 16'({4'b1110, 7'b0001110, 1'b1, 1'b1}));
    for (int i = 0; i < 11; i++) tick(4);

    // Change DATA mid-frame during digit 2's slot.
    n = 0;
    while (!(m_show && m_idx == 2) && n < 20) begin tick(4); n++; end
    cmp("reach_d2", 16'(m_idx), 16'd2);
    bus.data = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      tick(4);
      if (m_show && m_idx == 2) cmp("d2_still_A", 16'(tick_obs.seg), 16'(7'b0001000));
      if (m_show && m_idx == 3) cmp("d3_still_1", 16'(tick_obs.seg), 16'(7'b1111001));
      if (last.frame) begin
        cmp("d0_new_frame", 16'(tick_obs.seg), 16'(7'b1000000));
        break;
      end
    end

    // Digit 2 masked, its DP requested.
    bus.en_mask = 4'b1011; bus.dp = 4'b0100;
    for (int i = 0; i < 24; i++) begin
      tick(4);
      if (m_show && m_idx == 2) cmp("d2_masked_an", 16'(tick_obs.an), 16'hF);
      if (m_show && m_idx == 1) cmp("d1_no_dp", 16'(tick_obs.sdp), 16'd1);
    end

    // Reset in the middle of digit 1's SHOW.
    bus.en_mask = 4'hF; bus.dp = 4'h0;
    n = 0;
    while (!(m_show && m_idx == 1) && n < 20) begin tick(4); n++; end
    cmp("reach_d1", 16'(m_idx), 16'd1);
    q.delete();
    do_reset();
    tick(4);
    cmp("post_reset_frame", 16'(tick_obs), 16'({4'b1110, 7'b1000000, 1'b1, 1'b1}));

    // CE held high: every CLK is a tick.
    do_reset();
    f1 = -1; f2 = -1;
    for (int i = 0; i < 40; i++) begin
      tick(0);
      if (tick_obs.frame) begin
        if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
      end
    end
    @(negedge clk); bus.ce = 1'b0;
    cmp("first_frame_tick", 16'(f1), 16'd0);
    cmp("frame_period", 16'(f2 - f1), BLK ? 16'd12 : 16'd8);
    cmp("sb_drained", 16'(q.size()), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
